// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one single-port data memory between requesters m0 and m1.
// Build option DMEM_ARB_FIXED_PRIO_EN: m0 always wins a tie (default is round-robin).
module dmem_arbiter #(
    parameter int NBITS  = 32,
    parameter int ADDRSZ = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDRSZ-1:0] m0_addr,
    input  logic [NBITS-1:0]  m0_wdata,
    output logic              m0_ack,
    output logic [NBITS-1:0]  m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDRSZ-1:0] m1_addr,
    input  logic [NBITS-1:0]  m1_wdata,
    output logic              m1_ack,
    output logic [NBITS-1:0]  m1_rdata,
    output logic              mem_write_ena,
    output logic [ADDRSZ-1:0] mem_addr,
    output logic [NBITS-1:0]  mem_data_wr,
    input  logic [NBITS-1:0]  mem_data_rd,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mem_write_ena_q, mem_write_ena_d;
    logic [ADDRSZ-1:0] mem_addr_q, mem_addr_d;
    logic [NBITS-1:0]  mem_data_wr_q, mem_data_wr_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [NBITS-1:0]  m0_rdata_q, m0_rdata_d;
    logic [NBITS-1:0]  m1_rdata_q, m1_rdata_d;
    logic              busy_q, busy_d;
    logic              grant0_s, grant1_s;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Grant decision: m0 wins every tie.
    always_comb begin
        grant0_s = m0_req;
        grant1_s = m1_req & ~m0_req;
    end
`else
    logic rr_last_q, rr_last_d;

    // Grant decision: a tie goes to the requester not served last (rr_last_q = 1 means m1).
    always_comb begin
        grant0_s = m0_req & (~m1_req | rr_last_q);
        grant1_s = m1_req & ~grant0_s;
    end

    // Round-robin pointer follows whichever port completes its access.
    always_comb begin
        rr_last_d = rr_last_q;
        case (state_q)
            SERVE0:  rr_last_d = 1'b0;
            SERVE1:  rr_last_d = 1'b1;
            default: rr_last_d = rr_last_q;
        endcase
    end

    // Round-robin pointer register; reset favours m0 on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // Next-state and registered-output logic for the IDLE/SERVE FSM.
    always_comb begin
        state_d         = state_q;
        mem_write_ena_d = mem_write_ena_q;
        mem_addr_d      = mem_addr_q;
        mem_data_wr_d   = mem_data_wr_q;
        m0_ack_d        = 1'b0;
        m1_ack_d        = 1'b0;
        m0_rdata_d      = m0_rdata_q;
        m1_rdata_d      = m1_rdata_q;
        busy_d          = busy_q;
        case (state_q)
            IDLE: begin
                if (grant0_s) begin
                    state_d         = SERVE0;
                    mem_write_ena_d = m0_we;
                    mem_addr_d      = m0_addr;
                    mem_data_wr_d   = m0_wdata;
                    busy_d          = 1'b1;
                end else if (grant1_s) begin
                    state_d         = SERVE1;
                    mem_write_ena_d = m1_we;
                    mem_addr_d      = m1_addr;
                    mem_data_wr_d   = m1_wdata;
                    busy_d          = 1'b1;
                end else begin
                    mem_write_ena_d = 1'b0;
                    busy_d          = 1'b0;
                end
            end
            SERVE0: begin
                // A write leaves the requester's last read data untouched.
                m0_rdata_d      = mem_write_ena_q ? m0_rdata_q : mem_data_rd;
                m0_ack_d        = 1'b1;
                mem_write_ena_d = 1'b0;
                busy_d          = 1'b0;
                state_d         = IDLE;
            end
            SERVE1: begin
                m1_rdata_d      = mem_write_ena_q ? m1_rdata_q : mem_data_rd;
                m1_ack_d        = 1'b1;
                mem_write_ena_d = 1'b0;
                busy_d          = 1'b0;
                state_d         = IDLE;
            end
            default: begin
                state_d         = IDLE;
                mem_write_ena_d = 1'b0;
                busy_d          = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            mem_write_ena_q <= 1'b0;
            mem_addr_q      <= {ADDRSZ{1'b0}};
            mem_data_wr_q   <= {NBITS{1'b0}};
            m0_ack_q        <= 1'b0;
            m1_ack_q        <= 1'b0;
            m0_rdata_q      <= {NBITS{1'b0}};
            m1_rdata_q      <= {NBITS{1'b0}};
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_write_ena_q <= mem_write_ena_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_wr_q   <= mem_data_wr_d;
            m0_ack_q        <= m0_ack_d;
            m1_ack_q        <= m1_ack_d;
            m0_rdata_q      <= m0_rdata_d;
            m1_rdata_q      <= m1_rdata_d;
            busy_q          <= busy_d;
        end
    end

    assign mem_write_ena = mem_write_ena_q;
    assign mem_addr      = mem_addr_q;
    assign mem_data_wr   = mem_data_wr_q;
    assign m0_ack        = m0_ack_q;
    assign m1_ack        = m1_ack_q;
    assign m0_rdata      = m0_rdata_q;
    assign m1_rdata      = m1_rdata_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: queue-driven requesters, a behavioural memory and a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int NBITS  = 32;
    localparam int ADDRSZ = 5;
    localparam int DEPTH  = 32;

    typedef struct packed {
        logic              we;
        logic [ADDRSZ-1:0] addr;
        logic [NBITS-1:0]  wd;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [ADDRSZ-1:0] m0_addr = '0, m1_addr = '0;
    logic [NBITS-1:0]  m0_wdata = '0, m1_wdata = '0;
    logic              m0_ack, m1_ack, mem_write_ena, busy;
    logic [NBITS-1:0]  m0_rdata, m1_rdata, mem_data_wr, mem_data_rd;
    logic [ADDRSZ-1:0] mem_addr;

    dmem_arbiter #(.NBITS(NBITS), .ADDRSZ(ADDRSZ)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_write_ena(mem_write_ena), .mem_addr(mem_addr), .mem_data_wr(mem_data_wr),
        .mem_data_rd(mem_data_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port memory: combinational read, write at the rising edge, no reset.
    logic [NBITS-1:0] mem [DEPTH];
    logic             mem_clr = 1'b1;
    assign mem_data_rd = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_write_ena) begin
            mem[mem_addr] <= mem_data_wr;
        end
    end

    // Reference model state (transaction level).
    logic [NBITS-1:0]  r_mem [DEPTH];
    logic              r_busy = 1'b0, r_who = 1'b0, r_last = 1'b1, r_wena = 1'b0;
    logic              r_ack0 = 1'b0, r_ack1 = 1'b0;
    logic [ADDRSZ-1:0] r_addr = '0;
    logic [NBITS-1:0]  r_wd = '0, r_rd0 = '0, r_rd1 = '0;

    txn_t q0[$], q1[$];
    logic hold0 = 1'b1, hold1 = 1'b1;
    int   n_cmp = 0, n_bad = 0, cyc = 0;

    function automatic txn_t mk(input logic we, input logic [ADDRSZ-1:0] a, input logic [NBITS-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wd = d;
        return t;
    endfunction

    // Advance one clock: update the model from the inputs present at the edge, then pop acked requests.
    task automatic tick();
        logic pick;
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
        end else if (r_wena) begin
            r_mem[r_addr] = r_wd;
        end
        r_ack0 = 1'b0;
        r_ack1 = 1'b0;
        if (rst) begin
            r_busy = 1'b0; r_last = 1'b1; r_wena = 1'b0;
            r_addr = '0; r_wd = '0; r_rd0 = '0; r_rd1 = '0;
        end else if (r_busy) begin
            if (!r_wena) begin
                if (r_who) r_rd1 = r_mem[r_addr];
                else       r_rd0 = r_mem[r_addr];
            end
            if (r_who) r_ack1 = 1'b1;
            else       r_ack0 = 1'b1;
            r_last = r_who; r_busy = 1'b0; r_wena = 1'b0;
        end else if (m0_req || m1_req) begin
            if (m0_req && m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                pick = 1'b0;
`else
                pick = (r_last == 1'b1) ? 1'b0 : 1'b1;
`endif
            end else begin
                pick = m1_req;
            end
            r_who  = pick;
            r_busy = 1'b1;
            r_wena = pick ? m1_we    : m0_we;
            r_addr = pick ? m1_addr  : m0_addr;
            r_wd   = pick ? m1_wdata : m0_wdata;
        end else begin
            r_wena = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r_ack0 && q0.size() > 0) void'(q0.pop_front());
        if (r_ack1 && q1.size() > 0) void'(q1.pop_front());
    endtask

    // Present each queue head on its port; idle fields are scrambled.
    task automatic drive_ports();
        m0_req = hold0 && (q0.size() > 0);
        m1_req = hold1 && (q1.size() > 0);
        if (q0.size() > 0) begin
            m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wd;
        end else begin
            m0_we = 1'($urandom); m0_addr = ADDRSZ'($urandom); m0_wdata = $urandom;
        end
        if (q1.size() > 0) begin
            m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wd;
        end else begin
            m1_we = 1'($urandom); m1_addr = ADDRSZ'($urandom); m1_wdata = $urandom;
        end
    endtask

    task automatic test_reset();
        int first = -1;
        q0.push_back(mk(1'b0, 5'd7, 32'd0));
        q1.push_back(mk(1'b0, 5'd8, 32'd0));
        rst = 1'b1;
        drive_ports();
        for (int c = 0; c < 2; c++) begin
            tick();
            mem_clr = 1'b0;
            n_cmp++;
            if ({m0_ack, m1_ack, mem_write_ena, mem_addr, busy} !== 9'd0) begin
                n_bad++;
                $display("FAIL reset_state@%0d got=%b want=0", cyc, {m0_ack, m1_ack, mem_write_ena, mem_addr, busy});
            end
            drive_ports();
        end
        rst = 1'b0;
        for (int c = 0; c < 20 && (q0.size() + q1.size()) > 0; c++) begin
            tick();
            n_cmp++;
            if ({m0_ack, m1_ack, busy, mem_write_ena, mem_addr} !== {r_ack0, r_ack1, r_busy, r_wena, r_addr}) begin
                n_bad++;
                $display("FAIL reset_ctrl@%0d got=%b want=%b", cyc, {m0_ack, m1_ack, busy, mem_write_ena, mem_addr}, {r_ack0, r_ack1, r_busy, r_wena, r_addr});
            end
            if (first < 0 && m0_ack) first = 0;
            else if (first < 0 && m1_ack) first = 1;
            else first = first;
            drive_ports();
        end
        n_cmp++;
        if (first != 0 || (q0.size() + q1.size()) != 0) begin
            n_bad++;
            $display("FAIL first_grant got=%0d pending=%0d want=0/0", first, q0.size() + q1.size());
        end
    endtask

    task automatic test_single_port();
        int wcyc = 0;
        int ackt[$];
        logic [NBITS-1:0] got = '0;
        q0.push_back(mk(1'b1, 5'd1, 32'd123));
        q0.push_back(mk(1'b0, 5'd1, 32'd0));
        drive_ports();
        for (int c = 0; c < 20 && q0.size() > 0; c++) begin
            tick();
            n_cmp++;
            if ({m0_ack, m1_ack, busy, mem_write_ena, mem_addr, mem_data_wr, m0_rdata} !==
                {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_wd, r_rd0}) begin
                n_bad++;
                $display("FAIL single@%0d got=%h want=%h", cyc, {m0_ack, m1_ack, busy, mem_write_ena, mem_addr, mem_data_wr, m0_rdata},
                         {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_wd, r_rd0});
            end
            if (mem_write_ena) wcyc++;
            if (m0_ack) begin
                ackt.push_back(c + 1);
                got = m0_rdata;
            end
            drive_ports();
        end
        n_cmp++;
        if (wcyc != 1) begin
            n_bad++;
            $display("FAIL write_ena_width got=%0d want=1", wcyc);
        end
        n_cmp++;
        if (ackt.size() != 2 || ackt[0] != 2 || ackt[1] != 4) begin
            n_bad++;
            $display("FAIL ack_latency got_n=%0d want acks at cycles 2 and 4", ackt.size());
        end
        n_cmp++;
        if (got !== 32'd123) begin
            n_bad++;
            $display("FAIL readback got=%0d want=123", got);
        end
    endtask

    task automatic test_tie();
        int ord[$];
        logic [NBITS-1:0] got = '0;
        q0.push_back(mk(1'b1, 5'd0, 32'h0000_00AA));
        q1.push_back(mk(1'b1, 5'd0, 32'h0000_0055));
        q0.push_back(mk(1'b0, 5'd0, 32'd0));
        rst = 1'b1;
        drive_ports();
        for (int c = 0; c < 30 && (q0.size() + q1.size()) > 0; c++) begin
            tick();
            rst = 1'b0;
            n_cmp++;
            if ({m0_ack, m1_ack, busy, mem_write_ena, mem_addr, mem_data_wr, m0_rdata, m1_rdata} !==
                {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_wd, r_rd0, r_rd1}) begin
                n_bad++;
                $display("FAIL tie@%0d got=%h want=%h", cyc, {m0_ack, m1_ack, busy, mem_write_ena, mem_addr, mem_data_wr, m0_rdata, m1_rdata},
                         {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_wd, r_rd0, r_rd1});
            end
            if (m0_ack) begin
                ord.push_back(0);
                got = m0_rdata;
            end
            if (m1_ack) ord.push_back(1);
            drive_ports();
        end
        n_cmp++;
        if (ord.size() != 3 || ord[0] != 0 || ord[1] != 1 || ord[2] != 0) begin
            n_bad++;
            $display("FAIL tie_order got_n=%0d want m0,m1,m0", ord.size());
        end
        n_cmp++;
        if (got !== 32'h0000_0055) begin
            n_bad++;
            $display("FAIL tie_readback got=%h want=00000055", got);
        end
    endtask

    task automatic test_fairness();
        logic [NBITS-1:0] v2 = $urandom, v3 = $urandom;
        int prev = -1, n0 = 0, n1 = 0;
        q0.push_back(mk(1'b1, 5'd2, v2));
        q1.push_back(mk(1'b1, 5'd3, v3));
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 5'd2, 32'd0));
            q1.push_back(mk(1'b0, 5'd3, 32'd0));
        end
        drive_ports();
        for (int c = 0; c < 60 && (q0.size() + q1.size()) > 0; c++) begin
            tick();
            n_cmp++;
            if ({m0_ack, m1_ack, busy, mem_write_ena, mem_addr, mem_data_wr, m0_rdata, m1_rdata} !==
                {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_wd, r_rd0, r_rd1}) begin
                n_bad++;
                $display("FAIL fair@%0d got=%h want=%h", cyc, {m0_ack, m1_ack, busy, mem_write_ena, mem_addr, mem_data_wr, m0_rdata, m1_rdata},
                         {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_wd, r_rd0, r_rd1});
            end
            if (m0_ack || m1_ack) begin
                n_cmp++;
                if ((m0_ack && m1_ack) || (prev >= 0 && int'(m1_ack) == prev)) begin
                    n_bad++;
                    $display("FAIL alternate@%0d got=%b%b prev=%0d", cyc, m0_ack, m1_ack, prev);
                end
                prev = int'(m1_ack);
            end
            if (m0_ack) begin
                if (n0 > 0) begin
                    n_cmp++;
                    if (m0_rdata !== v2) begin
                        n_bad++;
                        $display("FAIL fair_rd0 got=%h want=%h", m0_rdata, v2);
                    end
                end
                n0++;
            end
            if (m1_ack) begin
                if (n1 > 0) begin
                    n_cmp++;
                    if (m1_rdata !== v3) begin
                        n_bad++;
                        $display("FAIL fair_rd1 got=%h want=%h", m1_rdata, v3);
                    end
                end
                n1++;
            end
            drive_ports();
        end
        n_cmp++;
        if (n0 != 5 || n1 != 5) begin
            n_bad++;
            $display("FAIL fair_count got=%0d/%0d want=5/5", n0, n1);
        end
    endtask

    task automatic test_reset_mid();
        logic [NBITS-1:0] got = '0;
        int nack = 0;
        q1.push_back(mk(1'b0, 5'd1, 32'd0));
        drive_ports();
        for (int c = 0; c < 20 && q1.size() > 0; c++) begin
            tick();
            n_cmp++;
            if ({m0_ack, m1_ack, busy, mem_write_ena, mem_addr, mem_data_wr, m0_rdata, m1_rdata} !==
                {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_wd, r_rd0, r_rd1}) begin
                n_bad++;
                $display("FAIL midrst@%0d got=%h want=%h", cyc, {m0_ack, m1_ack, busy, mem_write_ena, mem_addr, mem_data_wr, m0_rdata, m1_rdata},
                         {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_wd, r_rd0, r_rd1});
            end
            if (c == 0) begin
                rst = 1'b1;
            end else if (c == 1) begin
                rst = 1'b0;
                n_cmp++;
                if ({m1_ack, busy, m1_rdata} !== {1'b0, 1'b0, 32'd0}) begin
                    n_bad++;
                    $display("FAIL midrst_abort got=%b%b/%h want=00/0", m1_ack, busy, m1_rdata);
                end
            end else begin
                rst = 1'b0;
            end
            if (m1_ack) begin
                got = m1_rdata;
                nack++;
            end
            drive_ports();
        end
        n_cmp++;
        if (got !== 32'd123 || nack != 1) begin
            n_bad++;
            $display("FAIL midrst_reissue got=%0d acks=%0d want=123/1", got, nack);
        end
    endtask

    task automatic test_fixed_prio();
        int n0 = 0, n1 = 0, t0 = -1, t1 = -1;
        for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 5'd2, 32'd0));
        q1.push_back(mk(1'b0, 5'd3, 32'd0));
        drive_ports();
        for (int c = 0; c < 40 && (q0.size() + q1.size()) > 0; c++) begin
            tick();
            n_cmp++;
            if ({m0_ack, m1_ack, busy, mem_write_ena, mem_addr, m0_rdata, m1_rdata} !==
                {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_rd0, r_rd1}) begin
                n_bad++;
                $display("FAIL prio@%0d got=%h want=%h", cyc, {m0_ack, m1_ack, busy, mem_write_ena, mem_addr, m0_rdata, m1_rdata},
                         {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_rd0, r_rd1});
            end
            if (m0_ack) begin
                n0++;
                t0 = c;
            end
            if (m1_ack) begin
                n1++;
                t1 = c;
                n_cmp++;
                if (n0 != 4) begin
                    n_bad++;
                    $display("FAIL prio_order m1 acked after %0d m0 acks want=4", n0);
                end
            end
            drive_ports();
        end
        n_cmp++;
        if (n0 != 4 || n1 != 1 || t1 != t0 + 2) begin
            n_bad++;
            $display("FAIL prio_timing got=%0d/%0d dt=%0d want=4/1 dt=2", n0, n1, t1 - t0);
        end
    endtask

    task automatic test_random();
        int n0 = 0, n1 = 0;
        for (int i = 0; i < 40; i++) begin
            q0.push_back(mk(1'($urandom), ADDRSZ'($urandom), $urandom));
            q1.push_back(mk(1'($urandom), ADDRSZ'($urandom), $urandom));
        end
        drive_ports();
        for (int c = 0; c < 4000 && (q0.size() + q1.size()) > 0; c++) begin
            tick();
            n_cmp++;
            if ({m0_ack, m1_ack, busy, mem_write_ena, mem_addr, mem_data_wr, m0_rdata, m1_rdata} !==
                {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_wd, r_rd0, r_rd1}) begin
                n_bad++;
                $display("FAIL rand@%0d got=%h want=%h", cyc, {m0_ack, m1_ack, busy, mem_write_ena, mem_addr, mem_data_wr, m0_rdata, m1_rdata},
                         {r_ack0, r_ack1, r_busy, r_wena, r_addr, r_wd, r_rd0, r_rd1});
            end
            if (m0_ack) n0++;
            if (m1_ack) n1++;
            // Requests may be withdrawn before grant, never while being served.
            if (!(r_busy && !r_who)) hold0 = ($urandom_range(9, 0) != 0);
            if (!(r_busy && r_who))  hold1 = ($urandom_range(9, 0) != 0);
            drive_ports();
        end
        n_cmp++;
        if (n0 != 40 || n1 != 40) begin
            n_bad++;
            $display("FAIL rand_count got=%0d/%0d want=40/40", n0, n1);
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_tie();
`ifdef DMEM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_fairness();
`endif
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port data memory (`my_datamemory`) between requesters m0 and m1, e.g. the CPU load/store unit and a debug/DMA port.
- Registers the winning request onto the memory ports, captures read data, and returns a one-cycle ack to the served requester.
- Default policy is round-robin; one access completes every 2 cycles.

Parameters:
- NBITS, 32, data word width (matches `my_datamemory` NBITS).
- ADDRSZ, 5, word address width (matches `my_datamemory` ADDRSZ).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  requester 0 access request.
- m0_we  in  1  requester 0: 1 = write, 0 = read.
- m0_addr  in  ADDRSZ  requester 0 word address.
- m0_wdata  in  NBITS  requester 0 write data.
- m0_ack  out  1  one-cycle completion pulse to requester 0.
- m0_rdata  out  NBITS  requester 0 read data, valid while m0_ack = 1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0, for requester 1.
- mem_write_ena  out  1  to memory write_ena.
- mem_addr  out  ADDRSZ  to memory addr.
- mem_data_wr  out  NBITS  to memory data_wr.
- mem_data_rd  in  NBITS  from memory data_rd (combinational read of mem_addr).
- busy  out  1  high while an access is in SERVE0/SERVE1.

Behaviour:
- Memory contract: the write commits at the rising clk edge while write_ena = 1. data_rd reflects addr combinationally.
- Reset (sync, rst = 1 at the edge):
  - state = IDLE; mem_write_ena, mem_addr, mem_data_wr = 0.
  - m0_ack, m1_ack, m0_rdata, m1_rdata, busy = 0.
  - rr_last = 1, so m0 wins the first tie.
- FSM states: IDLE, SERVE0, SERVE1.
- IDLE:
  - Sample reqs at the clock edge.
  - If exactly one req is high, go to SERVEx for that requester.
  - If both are high, serve the requester not equal to rr_last.
  - On entry to SERVEx, register mx_addr, mx_wdata and mx_we onto mem_addr, mem_data_wr and mem_write_ena; set busy = 1.
  - If no req, stay in IDLE; mem_write_ena = 0 (mem_addr and mem_data_wr hold).
- SERVEx (exactly 1 cycle):
  - Memory ports are stable for the whole cycle.
  - At the exit edge:
    - a write commits in memory;
    - for a read, mem_data_rd is captured into mx_rdata;
    - mx_ack = 1 for the following cycle;
    - rr_last = x;
    - mem_write_ena = 0, busy = 0, state = IDLE.
  - For a write, mx_rdata holds its previous value.
- Latency: req sampled at edge E1 → SERVE during cycle 1 → ack and rdata valid in cycle 2, after E2. Throughput is 1 access per 2 cycles.
- Handshake:
  - The requester holds req/we/addr/wdata until it samples ack.
  - Request fields are latched at grant; changes after grant do not affect the current access.
  - req still high during the ack cycle is treated as a new request, sampled at edge E3.
  - req dropped before grant: no access, no ack.
- Only the served port's ack ever pulses; m0_ack and m1_ack are never both 1.
- The losing requester keeps waiting. With both reqs held continuously, service strictly alternates, so worst-case wait is 4 cycles.
- Reset mid-operation: rst high at the SERVEx exit edge.
  - A write presented that cycle still commits, because the memory has no reset.
  - No ack is issued and no rdata is captured.
  - FSM returns to IDLE and rr_last = 1.
- Address arithmetic: none; addresses pass through unmodified, and all ADDRSZ values are legal.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. When both reqs are high in IDLE, m0 always wins; rr_last is not used. m1 can starve while m0 keeps requesting.
- Undefined (default): round-robin as specified in Behaviour.

Test Plan:
- Reset: rst = 1 for 2 cycles with both reqs high → no acks, mem_write_ena = 0, mem_addr = 0, busy = 0. The first grant after release goes to m0.
- Single port: m0 writes 123 to addr 1 → mem_write_ena = 1 for exactly 1 cycle, m0_ack 2 cycles after the request was sampled. m0 then reads addr 1 → m0_rdata = 123 with m0_ack.
- Tie: m0 writes 0xAA and m1 writes 0x55, both to addr 0, requested in the same cycle → m0 served first, m1 next. A later read of addr 0 returns 0x55.
- Fairness: both hold read reqs for 8 accesses (addrs 2/3) → ack sequence m0, m1, m0, m1, …; each ack carries its own port's data; acks are never simultaneous.
- Reset mid-access: assert rst during SERVE1 of an m1 read of addr 1 → no m1_ack, state IDLE. A re-issued m1 read returns 123.
- DMEM_ARB_FIXED_PRIO_EN defined: both reqs held for 4 accesses → m0 acked 4 times, m1 never. After m0 drops, m1 is acked 2 cycles later.
